// File: rtl/vga_pkg.sv
// Shared raster constants and the coordinate type used by the sprite/tile ROM blocks.
package vga_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  // Exclusive end of the sync pulse.
  function automatic int sync_end(input int active, input int fp, input int sync);
    return active + fp + sync;
  endfunction

  localparam int H_TOTAL      = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int V_TOTAL      = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
  localparam int H_SYNC_START = sync_start(DEF_H_ACTIVE, DEF_H_FP);
  localparam int H_SYNC_END   = sync_end(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC);
  localparam int V_SYNC_START = sync_start(DEF_V_ACTIVE, DEF_V_FP);
  localparam int V_SYNC_END   = sync_end(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle: generator drives through master, renderers/DAC read through slave.
// frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_gen_if;
  import vga_pkg::*;

  // No handshake: every signal is a free-running registered output; pix_en
  // qualifies the cycle on which Q_X/Q_Y step to the next pixel.
  logic   pix_en;
  logic   vga_clk;
  coord_t Q_X;
  coord_t Q_Y;
  logic   active;
  logic   hsync_n;
  logic   vsync_n;
  logic   blank_n;
  logic   sync_n;
  logic   frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  modport master (
    output pix_en, vga_clk, Q_X, Q_Y, active, hsync_n, vsync_n, blank_n, sync_n, frame_start
`ifdef VGA_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    input pix_en, vga_clk, Q_X, Q_Y, active, hsync_n, vsync_n, blank_n, sync_n, frame_start
`ifdef VGA_FRAME_CNT_EN
    , input frame_cnt
`endif
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with sync/active flags decoded
// from the next count so they switch on the same edge as cnt.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   inc,
  output coord_t cnt,
  output logic   wrap,
  output logic   sync_n,
  output logic   in_active
);

  localparam int     TOTAL        = axis_total(ACTIVE, FP, SYNC, BP);
  localparam coord_t C_LAST       = coord_t'(TOTAL - 1);
  localparam coord_t C_ACTIVE     = coord_t'(ACTIVE);
  localparam coord_t C_SYNC_START = coord_t'(sync_start(ACTIVE, FP));
  localparam coord_t C_SYNC_END   = coord_t'(sync_end(ACTIVE, FP, SYNC));

  coord_t r_cnt;
  logic   r_sync_n;
  logic   r_in_active;
  coord_t w_next;

  assign wrap   = (r_cnt == C_LAST);
  assign w_next = wrap ? '0 : r_cnt + 1'b1;

  // Reset parks the axis on its last position so the first step lands on 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= C_LAST;
      r_sync_n    <= 1'b1;
      r_in_active <= 1'b0;
    end else if (inc) begin
      r_cnt       <= w_next;
      r_sync_n    <= !((w_next >= C_SYNC_START) && (w_next < C_SYNC_END));
      r_in_active <= (w_next < C_ACTIVE);
    end
  end

  assign cnt       = r_cnt;
  assign sync_n    = r_sync_n;
  assign in_active = r_in_active;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-enable divider plus horizontal/vertical axis counters.
// Define VGA_FRAME_CNT_EN to add the 16-bit frame counter output.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  o_vga
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  if (axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP) > 1024 ||
      axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP) > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit coordinate range");
  end
  if (CLK_DIV < 2) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 2");
  end

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_pix_en;
  logic             r_vga_clk;
  logic             r_frame_start;
  logic [DIV_W-1:0] w_div_next;

  coord_t w_h_cnt, w_v_cnt;
  logic   w_h_wrap, w_v_wrap;
  logic   w_hsync_n, w_vsync_n;
  logic   w_h_active, w_v_active;
  logic   w_v_inc;
  logic   w_frame_edge;

  assign w_div_next = (r_div_cnt == DIV_MAX) ? '0 : r_div_cnt + 1'b1;

  // pix_en/vga_clk decode the next divider value so they are flops, not gates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_pix_en  <= 1'b0;
      r_vga_clk <= 1'b0;
    end else begin
      r_div_cnt <= w_div_next;
      r_pix_en  <= (w_div_next == DIV_MAX);
      r_vga_clk <= (w_div_next >= DIV_HALF);
    end
  end

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clk(clk), .rst(rst), .inc(r_pix_en),
    .cnt(w_h_cnt), .wrap(w_h_wrap), .sync_n(w_hsync_n), .in_active(w_h_active)
  );

  assign w_v_inc = w_h_wrap & r_pix_en;

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clk(clk), .rst(rst), .inc(w_v_inc),
    .cnt(w_v_cnt), .wrap(w_v_wrap), .sync_n(w_vsync_n), .in_active(w_v_active)
  );

  // Both axes at their last position means the coming step lands on (0,0).
  assign w_frame_edge = r_pix_en & w_h_wrap & w_v_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_start <= 1'b0;
    end else if (r_pix_en) begin
      r_frame_start <= w_h_wrap & w_v_wrap;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (w_frame_edge) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign o_vga.frame_cnt = r_frame_cnt;
`else
  logic w_frame_edge_unused;
  assign w_frame_edge_unused = w_frame_edge;
`endif

  // Both in_active flops update on the same pix_en edge, so the AND is skew-free.
  assign o_vga.pix_en      = r_pix_en;
  assign o_vga.vga_clk     = r_vga_clk;
  assign o_vga.Q_X         = w_h_cnt;
  assign o_vga.Q_Y         = w_v_cnt;
  assign o_vga.active      = w_h_active & w_v_active;
  assign o_vga.blank_n     = w_h_active & w_v_active;
  assign o_vga.hsync_n     = w_hsync_n;
  assign o_vga.vsync_n     = w_vsync_n;
  assign o_vga.sync_n      = 1'b0;
  assign o_vga.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing, a tiny raster for
// full-frame behaviour, and CLK_DIV=4 for divider scaling.
module tb_vga_timing_gen;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #10 clk = ~clk;

  vga_timing_gen_if vif();
  vga_timing_gen_if sif();
  vga_timing_gen_if dif();

  vga_timing_gen #(.CLK_DIV(2)) u_dut (.clk(clk), .rst(rst), .o_vga(vif));

  // Tiny raster: H 8+2+3+2 = 15, V 4+1+2+1 = 8, hsync 10..12, vsync 5..6.
  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_small (.clk(clk), .rst(rst), .o_vga(sif));

  vga_timing_gen #(.CLK_DIV(4)) u_div4 (.clk(clk), .rst(rst), .o_vga(dif));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic pe, input logic vc,
                            input logic [9:0] x, input logic [9:0] y,
                            input logic act, input logic bn, input logic hs,
                            input logic vs, input logic fs, input logic sn,
                            input int x_last, input int y_last);
    check({tag, "_pix_en"}, pe, 0);
    check({tag, "_vga_clk"}, vc, 0);
    check({tag, "_q_x"}, x, x_last);
    check({tag, "_q_y"}, y, y_last);
    check({tag, "_active"}, act, 0);
    check({tag, "_blank_n"}, bn, 0);
    check({tag, "_hsync_n"}, hs, 1);
    check({tag, "_vsync_n"}, vs, 1);
    check({tag, "_frame_start"}, fs, 0);
    check({tag, "_sync_n"}, sn, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state, asserted between clock edges.
    #1 rst = 1'b1;
    #4;
    check_idle("rst", vif.pix_en, vif.vga_clk, vif.Q_X, vif.Q_Y, vif.active, vif.blank_n,
               vif.hsync_n, vif.vsync_n, vif.frame_start, vif.sync_n, 799, 524);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // First pix_en then the step onto (0,0).
    @(negedge clk);
    check("first_pix_en", vif.pix_en, 1);
    check("first_hold_q_x", vif.Q_X, 799);
    @(negedge clk);
    check("start_pix_en", vif.pix_en, 0);
    check("start_q_x", vif.Q_X, 0);
    check("start_q_y", vif.Q_Y, 0);
    check("start_active", vif.active, 1);
    check("start_blank_n", vif.blank_n, 1);
    check("start_frame_start", vif.frame_start, 1);
    check("start_hsync_n", vif.hsync_n, 1);
    check("start_vsync_n", vif.vsync_n, 1);

    // One full default line.
    begin
      int n = 0, hs_n = 0, hs_first = -1, hs_last = -1, act_fall = -1, stray = 0, vsame = 0;
      logic pv = vif.vga_clk;
      logic ppe = vif.pix_en;
      logic [9:0] px = vif.Q_X;
      for (int c = 0; c < 4000; c++) begin
        @(negedge clk);
        if (vif.vga_clk == pv) vsame++;
        pv = vif.vga_clk;
        if (vif.Q_X != px && !ppe) stray++;
        px = vif.Q_X;
        ppe = vif.pix_en;
        if (vif.pix_en) begin
          if (vif.Q_X == 0 && n > 0) break;
          n++;
          if (!vif.hsync_n) begin
            hs_n++;
            if (hs_first < 0) hs_first = int'(vif.Q_X);
            hs_last = int'(vif.Q_X);
          end
          if (!vif.active && act_fall < 0) act_fall = int'(vif.Q_X);
        end
      end
      check("line_pix_en_count", n, 800);
      check("line_hsync_width", hs_n, 96);
      check("line_hsync_first", hs_first, 656);
      check("line_hsync_last", hs_last, 751);
      check("line_active_fall", act_fall, 640);
      check("line_stray_steps", stray, 0);
      check("line_vga_clk_toggle", vsame, 0);
      check("line_next_q_y", vif.Q_Y, 1);
    end

    // One full frame of the tiny raster.
    do_reset();
    begin
      int fs1 = -1, per = -1, pe_n = 0, vs_n = 0, vs_min = 99, vs_max = -1;
      int act_n = 0, fs_hi = 0, ymax = 0, xmax = 0, wraps = 0, wrap_bad = 0;
      logic pfs = 1'b0;
      logic in_frame = 1'b0;
      logic [9:0] px = sif.Q_X;
      logic [9:0] py = sif.Q_Y;
      for (int c = 0; c < 2000; c++) begin
        @(negedge clk);
        if (in_frame) begin
          if (sif.frame_start) fs_hi++;
          if (int'(sif.Q_Y) > ymax) ymax = int'(sif.Q_Y);
          if (int'(sif.Q_X) > xmax) xmax = int'(sif.Q_X);
          if (px == 14 && py == 7 && (sif.Q_X != px || sif.Q_Y != py)) begin
            wraps++;
            if (sif.Q_X != 0 || sif.Q_Y != 0) wrap_bad++;
          end
          if (sif.pix_en) begin
            pe_n++;
            if (sif.active) act_n++;
            if (!sif.vsync_n) begin
              vs_n++;
              if (int'(sif.Q_Y) < vs_min) vs_min = int'(sif.Q_Y);
              if (int'(sif.Q_Y) > vs_max) vs_max = int'(sif.Q_Y);
            end
          end
        end
        px = sif.Q_X;
        py = sif.Q_Y;
        if (sif.frame_start && !pfs) begin
          if (fs1 < 0) begin
            fs1 = c;
            in_frame = 1'b1;
            check("frame_fs_q_x", sif.Q_X, 0);
            check("frame_fs_q_y", sif.Q_Y, 0);
          end else begin
            per = c - fs1;
            break;
          end
        end
        pfs = sif.frame_start;
      end
      check("frame_period_clk", per, 240);
      check("frame_pix_en_count", pe_n, 120);
      check("frame_vsync_pixels", vs_n, 30);
      check("frame_vsync_first_y", vs_min, 5);
      check("frame_vsync_last_y", vs_max, 6);
      check("frame_active_pixels", act_n, 32);
      check("frame_start_width_clk", fs_hi, 2);
      check("frame_q_y_max", ymax, 7);
      check("frame_q_x_max", xmax, 14);
      check("frame_wrap_count", wraps, 1);
      check("frame_wrap_bad", wrap_bad, 0);
    end

    // Asynchronous reset in the middle of hsync and vsync.
    begin
      logic found = 1'b0;
      for (int c = 0; c < 1000; c++) begin
        @(negedge clk);
        if (sif.Q_X == 11 && sif.Q_Y == 5) begin
          found = 1'b1;
          break;
        end
      end
      check("mid_found", found, 1);
      check("mid_hsync_n", sif.hsync_n, 0);
      check("mid_vsync_n", sif.vsync_n, 0);
      #3 rst = 1'b1;
      #1;
      check_idle("mid_rst", sif.pix_en, sif.vga_clk, sif.Q_X, sif.Q_Y, sif.active, sif.blank_n,
                 sif.hsync_n, sif.vsync_n, sif.frame_start, sif.sync_n, 14, 7);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_restart_q_x", sif.Q_X, 0);
      check("mid_restart_q_y", sif.Q_Y, 0);
      check("mid_restart_frame_start", sif.frame_start, 1);
    end

    // CLK_DIV=4 line period and duty.
    do_reset();
    begin
      int ev = 0, c0 = 0, per = -1, pe_n = 0, vc_n = 0;
      logic [9:0] px = dif.Q_X;
      for (int c = 0; c < 8000; c++) begin
        @(negedge clk);
        if (ev == 1) begin
          if (dif.pix_en) pe_n++;
          if (dif.vga_clk) vc_n++;
        end
        if (dif.Q_X == 0 && px != 0) begin
          ev++;
          if (ev == 1) c0 = c;
          else begin
            per = c - c0;
            break;
          end
        end
        px = dif.Q_X;
      end
      check("div4_line_period_clk", per, 3200);
      check("div4_pix_en_count", pe_n, 800);
      check("div4_vga_clk_high", vc_n, 1600);
    end

`ifdef VGA_FRAME_CNT_EN
    do_reset();
    begin
      int k = 0;
      logic pfs = 1'b0;
      for (int c = 0; c < 2000 && k < 3; c++) begin
        @(negedge clk);
        if (sif.frame_start && !pfs) begin
          k++;
          check($sformatf("fcnt_frame_%0d", k), sif.frame_cnt, k);
        end
        pfs = sif.frame_start;
      end
      check("fcnt_frames_seen", k, 3);
      @(negedge clk);
      force u_small.r_frame_cnt = 16'hFFFF;
      @(negedge clk);
      release u_small.r_frame_cnt;
      k = 0;
      pfs = sif.frame_start;
      for (int c = 0; c < 1000; c++) begin
        @(negedge clk);
        if (sif.frame_start && !pfs) begin
          k = 1;
          break;
        end
        pfs = sif.frame_start;
      end
      check("fcnt_wrap_seen", k, 1);
      check("fcnt_wrap_value", sif.frame_cnt, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator that sits directly upstream of the sprite/tile renderers.
- Produces the pixel coordinates Q_X/Q_Y that every sprite ROM block consumes.
- Also produces the sync, blank and pixel-clock signals for the VGA DAC.
- Runs from the 50 MHz system clock; advances the raster once per pixel-enable strobe (25 MHz for 640x480@60).

Parameters:
- CLK_DIV, 2, system clocks per pixel (≥2).
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, hsync pulse width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vsync pulse width (lines).
- V_BP, 33, vertical back porch (lines).

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset, asynchronous, active-high
- pix_en  out  1  one-clk strobe; raster advances on this edge
- vga_clk  out  1  DAC pixel clock, 50% duty at CLK_DIV=2
- Q_X  out  10  horizontal count 0..H_TOTAL-1
- Q_Y  out  10  vertical count 0..V_TOTAL-1
- active  out  1  high when Q_X<H_ACTIVE and Q_Y<V_ACTIVE
- hsync_n  out  1  horizontal sync, active-low
- vsync_n  out  1  vertical sync, active-low
- blank_n  out  1  equals active (DAC blank, active-low)
- sync_n  out  1  constant 0 (no sync-on-green)
- frame_start  out  1  one-pix_en-wide pulse at the (0,0) pixel

Behaviour:
- Clock and reset: single clock domain, clk only. Reset is asynchronous and active-high.
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pix_en is registered and high for exactly one clk when div_cnt==CLK_DIV-1. vga_clk is registered and high while div_cnt ≥ CLK_DIV/2.
- Horizontal counter: h_cnt advances only on pix_en and wraps H_TOTAL-1 → 0.
- Vertical counter: v_cnt advances on pix_en only when h_cnt wraps, and wraps V_TOTAL-1 → 0.
- All outputs are registered. hsync_n, vsync_n, active, blank_n and frame_start are decoded from next-count values, so they change on the same edge as Q_X/Q_Y (zero skew, no glitches).
- hsync_n = 0 iff H_ACTIVE+H_FP ≤ Q_X < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
- vsync_n = 0 iff V_ACTIVE+V_FP ≤ Q_Y < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
- frame_start = 1 for exactly one pix_en period, when Q_X=0 and Q_Y=0.
- Reset values: div_cnt=0, pix_en=0, vga_clk=0, Q_X=H_TOTAL-1 (799), Q_Y=V_TOTAL-1 (524), active=0, blank_n=0, hsync_n=1, vsync_n=1, frame_start=0.
- The first pix_en after reset moves the raster to (0,0) and asserts frame_start.
- Reset mid-frame: all outputs return to reset values immediately, without waiting for a clk edge. No partial line is completed.
- Simultaneous h wrap and v wrap (799,524 → 0,0) is the frame boundary: both counters wrap on the same edge.
- Counter widths are 10 bits. Parameter sets with H_TOTAL or V_TOTAL > 1024 are illegal and are flagged by an elaboration-time assertion.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- Defined: adds output port frame_cnt [15:0]. It resets to 0, increments on every frame_start, and wraps 65535 → 0. Sprite logic uses it for animation.
- Undefined: no port and no counter logic. All other behaviour is identical.

Decomposition:
- Package vga_pkg holds:
  - Default timing constants.
  - H_TOTAL and V_TOTAL as localparam functions.
  - Sync-start and sync-end constants.
  - COORD_W=10.
  - Typedef coord_t = logic [COORD_W-1:0], shared with the sprite/tile ROM blocks.
- One sub-module: vga_axis_counter, parameterised by ACTIVE/FP/SYNC/BP. It has inputs clk, rst, inc and outputs cnt, wrap, sync_n, in_active, and is instantiated once per axis. The vertical instance's inc is horizontal wrap AND pix_en.

Test Plan:
- Reset released, then 2 clk → pix_en pulses once; Q_X=0, Q_Y=0, active=1, frame_start=1, hsync_n=1, vsync_n=1.
- Free run one line → exactly 800 pix_en between Q_X=0 events; hsync_n low exactly 96 pix_en, first at Q_X=656, last at 751; active falls at Q_X=640.
- Free run one frame → vsync_n low for Q_Y=490..491 (1600 pix_en); frame_start period = 420000 pix_en = 840000 clk; Q_Y never exceeds 524.
- vga_clk and pix_en at CLK_DIV=2 → vga_clk toggles every clk; pix_en high on every second clk; no raster step without pix_en. At CLK_DIV=4 → line period 3200 clk.
- Assert rst asynchronously between clk edges at (300,200) → outputs at reset values before the next edge; after release the raster restarts at (0,0).
- With VGA_FRAME_CNT_EN, run 3 frames → frame_cnt reads 1, 2, 3 after successive frame_start pulses. Force frame_cnt to 65535 → the next frame gives 0.
